// File: rtl/bbus_seq_pkg.sv
// bbus_seq_pkg: sequencer states, opcode class constants and the decoded IR class record
package bbus_seq_pkg;
  typedef enum logic [3:0] {
    S_HALT, S_FETCH, S_INCPC, S_DECODE, S_BRANCH, S_LSEA, S_MEM, S_PUSH, S_PUSHW, S_CALL
  } state_e;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_BR = 4'h1;
  localparam logic [3:0] OP_LD = 4'h2;
  localparam logic [3:0] OP_ST = 4'h3;
  localparam logic [3:0] OP_CALL = 4'h4;
  localparam logic [15:0] IR_HALT = 16'h0000;
  typedef struct packed {
    logic nop;
    logic halt;
    logic br;
    logic ld;
    logic st;
    logic call;
    logic ill;
  } ir_class_t;
endpackage

// File: rtl/bbus_seq_class.sv
// bseq_class: combinational IR -> instruction class decoder (in IR[15:0], out cls one-hot class)
module bseq_class
  import bbus_seq_pkg::*;
(
  input  logic [15:0] IR,
  output ir_class_t   cls
);
  logic [3:0] op;
  assign op = IR[15:12];
  always_comb begin
    cls.halt = IR == IR_HALT;
    cls.nop = op == OP_NOP && IR != IR_HALT;
    cls.br = op == OP_BR;
    cls.ld = op == OP_LD;
    cls.st = op == OP_ST;
    cls.call = op == OP_CALL;
    cls.ill = op > OP_CALL;
  end
endmodule

// File: rtl/bbus_seq.sv
// bbus_seq: fetch/incpc/decode/execute sequencer driving BBUS selects (CON_0..IRLSOF), MEM_REQ/WE, load strobes, FAULT, HALTED from CLK, RST_N, IR, MEM_RDY, BR_TAKEN, START
module bbus_seq
  import bbus_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IR,
  input  logic        MEM_RDY,
  input  logic        BR_TAKEN,
  input  logic        START,
  output logic        CON_0,
  output logic        CON_2,
  output logic        CON__4,
  output logic        IRBROF,
  output logic        IRLSOF,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        IR_LD,
  output logic        PC_LD,
  output logic        MAR_LD,
  output logic        SP_LD,
  output logic        RF_WE,
  output logic        FAULT,
  output logic        HALTED
);
  state_e    state_q, state_d;
  logic      st_q, st_d;
  ir_class_t cls;
  bseq_class u_class (.IR(IR), .cls(cls));
  always_comb begin
    state_d = state_q;
    st_d = st_q;
    case (state_q)
      S_HALT:   state_d = START ? S_FETCH : S_HALT;
      S_FETCH:  state_d = MEM_RDY ? S_INCPC : S_FETCH;
      S_INCPC:  state_d = S_DECODE;
      S_DECODE: begin
        st_d = cls.st;
        state_d = cls.halt ? S_HALT :
                  (cls.ld | cls.st) ? S_LSEA :
                  cls.call ? S_PUSH :
                  (cls.br & BR_TAKEN) ? S_BRANCH : S_FETCH;
      end
      S_BRANCH: state_d = S_FETCH;
      S_LSEA:   state_d = S_MEM;
      S_MEM:    state_d = MEM_RDY ? S_FETCH : S_MEM;
      S_PUSH:   state_d = S_PUSHW;
      S_PUSHW:  state_d = MEM_RDY ? S_CALL : S_PUSHW;
      S_CALL:   state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_HALT;
      st_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q <= st_d;
    end
  end
  assign CON_0 = state_q == S_FETCH;
  assign CON_2 = state_q == S_INCPC;
  assign CON__4 = state_q == S_PUSH;
  assign IRBROF = state_q == S_BRANCH || state_q == S_CALL;
  assign IRLSOF = state_q == S_LSEA;
  assign MEM_REQ = state_q == S_FETCH || state_q == S_MEM || state_q == S_PUSHW;
  assign MEM_WE = (state_q == S_MEM && st_q) || state_q == S_PUSHW;
  assign IR_LD = state_q == S_FETCH && MEM_RDY;
  assign PC_LD = state_q == S_INCPC || state_q == S_BRANCH || state_q == S_CALL;
  assign MAR_LD = state_q == S_FETCH || state_q == S_LSEA || state_q == S_PUSH;
  assign SP_LD = state_q == S_PUSH;
  assign RF_WE = state_q == S_MEM && !st_q && MEM_RDY;
  assign FAULT = state_q == S_DECODE && cls.ill;
  assign HALTED = state_q == S_HALT;
endmodule

// File: tb/tb_bbus_seq.sv
// tb_bbus_seq: randomized instruction stream checked cycle by cycle against a phase-list reference model
module tb_bbus_seq;
  logic CLK = 1'b0, RST_N = 1'b0, MEM_RDY = 1'b0, BR_TAKEN = 1'b0, START = 1'b0;
  logic [15:0] IR = 16'h0;
  logic CON_0, CON_2, CON__4, IRBROF, IRLSOF, MEM_REQ, MEM_WE, IR_LD, PC_LD, MAR_LD, SP_LD, RF_WE, FAULT, HALTED;
  logic [13:0] obs;
  int errors = 0, checks = 0;
  localparam logic [13:0] B_C0 = 14'h2000, B_C2 = 14'h1000, B_C4 = 14'h0800, B_BR = 14'h0400,
    B_LS = 14'h0200, B_REQ = 14'h0100, B_WE = 14'h0080, B_IRLD = 14'h0040, B_PC = 14'h0020,
    B_MAR = 14'h0010, B_SP = 14'h0008, B_RF = 14'h0004, B_FLT = 14'h0002, B_HLT = 14'h0001;
  bbus_seq dut (
    .CLK(CLK), .RST_N(RST_N), .IR(IR), .MEM_RDY(MEM_RDY), .BR_TAKEN(BR_TAKEN), .START(START),
    .CON_0(CON_0), .CON_2(CON_2), .CON__4(CON__4), .IRBROF(IRBROF), .IRLSOF(IRLSOF),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .IR_LD(IR_LD), .PC_LD(PC_LD), .MAR_LD(MAR_LD),
    .SP_LD(SP_LD), .RF_WE(RF_WE), .FAULT(FAULT), .HALTED(HALTED)
  );
  always #5 CLK = ~CLK;
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic cyc(input logic [13:0] e, input logic rdy, input logic st, input string tag);
    MEM_RDY = rdy;
    START = st;
    @(negedge CLK);
    obs = {CON_0, CON_2, CON__4, IRBROF, IRLSOF, MEM_REQ, MEM_WE, IR_LD, PC_LD, MAR_LD, SP_LD, RF_WE, FAULT, HALTED};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s outputs=%h expected=%h", tag, obs, e);
    end
    checks++;
    assert ($onehot0(obs[13:9]) === 1'b1) else begin
      errors++;
      $error("FAIL %s_onesel selects=%b expected at most one", tag, obs[13:9]);
    end
    @(posedge CLK);
    #1;
  endtask
  task automatic run(input logic [15:0] ir, input logic br, input int wf, input int wm);
    logic [3:0] op;
    op = ir[15:12];
    IR = ir;
    BR_TAKEN = br;
    for (int i = 0; i < wf; i++) cyc(B_C0 | B_MAR | B_REQ, 1'b0, rb(), "fetch_wait");
    cyc(B_C0 | B_MAR | B_REQ | B_IRLD, 1'b1, rb(), "fetch");
    cyc(B_C2 | B_PC, rb(), rb(), "incpc");
    cyc(op > 4'h4 ? B_FLT : 14'h0, rb(), rb(), "decode");
    if (op == 4'h1 && br) cyc(B_BR | B_PC, rb(), rb(), "branch");
    if (op == 4'h2 || op == 4'h3) begin
      cyc(B_LS | B_MAR, rb(), rb(), "lsea");
      for (int i = 0; i < wm; i++) cyc(B_REQ | (op == 4'h3 ? B_WE : 14'h0), 1'b0, rb(), "mem_wait");
      cyc(B_REQ | (op == 4'h3 ? B_WE : B_RF), 1'b1, rb(), "mem");
    end
    if (op == 4'h4) begin
      cyc(B_C4 | B_SP | B_MAR, rb(), rb(), "push");
      for (int i = 0; i < wm; i++) cyc(B_REQ | B_WE, 1'b0, rb(), "pushw_wait");
      cyc(B_REQ | B_WE, 1'b1, rb(), "pushw");
      cyc(B_BR | B_PC, rb(), rb(), "call");
    end
  endtask
  initial begin
    logic [15:0] ir;
    @(posedge CLK);
    #1;
    cyc(B_HLT, 1'b1, 1'b1, "reset");
    RST_N = 1'b1;
    cyc(B_HLT, 1'b1, 1'b0, "halt_idle");
    cyc(B_HLT, 1'b0, 1'b1, "halt_start");
    run(16'h0100, 1'b0, 0, 0);
    run(16'h0100, 1'b1, 0, 0);
    run(16'h1023, 1'b1, 0, 0);
    run(16'h1023, 1'b0, 1, 0);
    run(16'h2045, 1'b0, 0, 2);
    run(16'h3045, 1'b1, 0, 1);
    run(16'h4000, 1'b0, 0, 0);
    run(16'hA000, 1'b0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: ir = {4'h0, 12'($urandom) | 12'h001};
        1: ir = {4'h1, 12'($urandom)};
        2: ir = {4'h2, 12'($urandom)};
        3: ir = {4'h3, 12'($urandom)};
        4: ir = {4'h4, 12'($urandom)};
        default: ir = {4'($urandom_range(5, 15)), 12'($urandom)};
      endcase
      run(ir, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    run(16'h0000, 1'b1, 0, 0);
    cyc(B_HLT, 1'b1, 1'b0, "halted");
    cyc(B_HLT, 1'b0, 1'b0, "halted_hold");
    cyc(B_HLT, 1'b1, 1'b1, "restart");
    IR = 16'h2045;
    cyc(B_C0 | B_MAR | B_REQ | B_IRLD, 1'b1, 1'b0, "fetch");
    cyc(B_C2 | B_PC, 1'b0, 1'b0, "incpc");
    cyc(14'h0, 1'b0, 1'b0, "decode");
    cyc(B_LS | B_MAR, 1'b0, 1'b0, "lsea");
    cyc(B_REQ, 1'b0, 1'b0, "mem_wait");
    RST_N = 1'b0;
    cyc(B_REQ, 1'b0, 1'b1, "mem_wait_rst");
    cyc(B_HLT, 1'b1, 1'b1, "rst_mid_mem");
    RST_N = 1'b1;
    cyc(B_HLT, 1'b1, 1'b1, "post_rst_start");
    run(16'h0123, 1'b0, 0, 0);
    cyc(B_C0 | B_MAR | B_REQ, 1'b0, 1'b0, "final_fetch");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bbus_seq.md
# bbus_seq

Control sequencer that drives the BBUS select strobes of the constant/offset mux (CON_0, CON_2, CON__4, IRBROF, IRLSOF) plus the datapath and memory load strobes. It walks fetch, PC increment, decode and execute phases, and issues at most one BBUS select per cycle. It sits between the instruction register and the ALU/memory datapath, and is the initiator side of the BBUS select interface.

## Interface
- No parameters.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  synchronous, active-low reset.
- IR  in  16  current instruction register contents.
- MEM_RDY  in  1  memory completes the current request; sampled only while MEM_REQ=1.
- BR_TAKEN  in  1  branch condition result from flag logic; valid in DECODE.
- START  in  1  leave HALT; sampled only in HALT.
- CON_0, CON_2, CON__4, IRBROF, IRLSOF  out  1 each  BBUS selects; at most one high per cycle.
- MEM_REQ  out  1  memory request.
- MEM_WE  out  1  write qualifier for MEM_REQ.
- IR_LD, PC_LD, MAR_LD, SP_LD, RF_WE  out  1 each  datapath load strobes.
- FAULT  out  1  one-cycle pulse on an illegal opcode.
- HALTED  out  1  high while in HALT.

## Operation
- Decode uses IR[15:12].
  - 0x1 branch.
  - 0x2 load.
  - 0x3 store.
  - 0x4 call.
  - 0x0 is a NOP; IR==16'h0000 is halt.
  - 0x5–0xF are illegal.
- States and transitions:
  - HALT: all strobes 0, HALTED=1. START=1 -> FETCH.
  - FETCH: CON_0, MAR_LD, MEM_REQ. Stay until MEM_RDY. IR_LD = MEM_RDY (Mealy). On MEM_RDY -> INCPC.
  - INCPC: CON_2, PC_LD -> DECODE.
  - DECODE: no select, so BBUS=0. Next state:
    - branch with BR_TAKEN=1 -> BRANCH; branch with BR_TAKEN=0 -> FETCH.
    - load/store -> LSEA.
    - call -> PUSH.
    - halt -> HALT.
    - NOP -> FETCH.
    - illegal -> FETCH, with FAULT=1 in this cycle.
  - BRANCH: IRBROF, PC_LD -> FETCH.
  - LSEA: IRLSOF, MAR_LD -> MEM.
  - MEM: MEM_REQ, and MEM_WE for store. RF_WE = MEM_RDY for load (Mealy). On MEM_RDY -> FETCH.
  - PUSH: CON__4, SP_LD, MAR_LD -> PUSHW.
  - PUSHW: MEM_REQ, MEM_WE (stores PC). On MEM_RDY -> CALL.
  - CALL: IRBROF, PC_LD -> FETCH.
- All outputs are decoded from the state register. Only IR_LD, RF_WE and FAULT also depend on inputs.
- The IR class is decoded from IR as seen in DECODE. The state remembers load vs store for MEM.

## Timing
- Reset: next edge with RST_N=0 forces HALT. All outputs are 0 except HALTED=1.
- Reset has priority over every transition, including mid-memory-request. An outstanding request is abandoned: MEM_REQ drops on the reset edge.
- Memory handshake:
  - MEM_REQ, MEM_WE and the phase's BBUS select stay stable until the edge where MEM_RDY=1.
  - The transfer completes on that edge.
  - MEM_RDY while MEM_REQ=0 is ignored.
- Latency, in cycles, with MEM_RDY already high on entry to each memory state:
  - NOP or not-taken branch: 3.
  - Taken branch: 4.
  - Load or store: 5.
  - Call: 6.
  - Each wait cycle on MEM_RDY adds 1.
- START is ignored outside HALT. A halt instruction enters HALT on the edge after DECODE. START is sampled from the first HALT cycle on.
- FAULT is asserted only in the DECODE cycle; it is never held.

## Structure
- Shared package holds:
  - the state enum (HALT, FETCH, INCPC, DECODE, BRANCH, LSEA, MEM, PUSH, PUSHW, CALL);
  - opcode class constants OP_NOP=4'h0, OP_BR=4'h1, OP_LD=4'h2, OP_ST=4'h3, OP_CALL=4'h4;
  - IR_HALT=16'h0000.
- One natural sub-module: bseq_class, a combinational IR -> class decoder (nop/halt/br/ld/st/call/illegal).
- The FSM and output decode live in bbus_seq.

## Test plan
- Reset then START; IR=16'h0100 (NOP); MEM_RDY held 1 -> FETCH/INCPC/DECODE repeat every 3 cycles. CON_0 is high in cycle 1 and CON_2 in cycle 2; no other select fires.
- IR=16'h1000|offset, BR_TAKEN=1 -> IRBROF+PC_LD for exactly 1 cycle after DECODE. With BR_TAKEN=0 there is no IRBROF and the next cycle is FETCH.
- Load IR=16'h2045 with MEM_RDY low for 2 MEM cycles -> MEM_REQ held 3 cycles, MEM_WE=0, RF_WE=1 only in the last. Store (16'h3045) -> MEM_WE=1 and RF_WE never asserted.
- Call IR=16'h4000 -> sequence CON__4 (SP_LD, MAR_LD), then MEM_REQ+MEM_WE, then IRBROF+PC_LD; 6 cycles total.
- IR=16'hA000 -> FAULT pulses 1 cycle in DECODE, then FETCH. IR=16'h0000 -> HALTED=1. START ignored while running; START in HALT -> FETCH next edge.
- RST_N=0 during a MEM wait -> next edge all outputs 0, HALTED=1, MEM_REQ deasserted. Every cycle of every test checks that at most one BBUS select is high.
